// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the RV32I load/store unit.
//   addr_ctrl_e : funct3 width/sign codes (loads; stores reuse 000/001/010)
//   lsu_state_e : bus sequencing states
//   size_mask   : byte-enable pattern of an access before lane shifting
//   is_legal    : whether a funct3 code is valid for a load or a store
//   is_split    : whether an access crosses a word boundary
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } addr_ctrl_e;

  // Store codes share the encodings of the signed loads.
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_WAIT0 = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    logic [3:0] m;
    case (ctrl[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_legal(input logic write, input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~write;  // unsigned variants exist only for loads
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_split(input logic [2:0] ctrl, input logic [1:0] off);
    logic s;
    case (ctrl[1:0])
      2'b10:   s = (off != 2'b00);
      2'b01:   s = (off == 2'b11);
      default: s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   ctrl, off          : funct3 code and byte offset of the access
//   st_data            : right-aligned store data
//   ld_lo, ld_hi       : first and second bus words of a load (ld_hi = 0 if unsplit)
//   be_lo/be_hi        : byte enables for beat 0 / beat 1
//   wdata_lo/wdata_hi  : lane-shifted store data for beat 0 / beat 1
//   ld_data            : merged, extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] ld_data
);

  logic [7:0]  be_wide;
  logic [63:0] st_wide;
  logic [63:0] ld_wide;

  // Shift across a two-word window: the upper half is what spills into beat 1.
  always_comb begin
    be_wide  = {4'b0000, size_mask(ctrl)} << off;
    st_wide  = {32'h0000_0000, st_data} << {off, 3'b000};
    ld_wide  = {ld_hi, ld_lo} >> {off, 3'b000};
    be_lo    = be_wide[3:0];
    be_hi    = be_wide[7:4];
    wdata_lo = st_wide[31:0];
    wdata_hi = st_wide[63:32];
    case (ctrl)
      3'b000:  ld_data = {{24{ld_wide[7]}}, ld_wide[7:0]};
      3'b001:  ld_data = {{16{ld_wide[15]}}, ld_wide[15:0]};
      3'b010:  ld_data = ld_wide[31:0];
      3'b100:  ld_data = {24'h00_0000, ld_wide[7:0]};
      3'b101:  ld_data = {16'h0000, ld_wide[15:0]};
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store engine for an RV32I pipeline.
//   req_*  : request from the memory stage (valid/ready handshake)
//   resp_* : one-cycle completion pulse with extended load data or error
//   mem_*  : word-aligned data-memory bus (req held until gnt, rvalid returns data)
// Word-crossing accesses are split into two bus beats. All outputs are flops.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_addr_ctrl,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(3'd4);

  lsu_state_e state_q, state_d;

  logic                  write_q, write_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  accept;
  logic                  split;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] ld_lo, ld_hi, ld_data;
  logic [DATA_WIDTH-1:0] wdata_lo, wdata_hi;
  logic [3:0]            be_lo, be_hi;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

  lsu_align u_align (
    .ctrl     (ctrl_d),
    .off      (addr_d[1:0]),
    .st_data  (wdata_d),
    .ld_lo    (ld_lo),
    .ld_hi    (ld_hi),
    .be_lo    (be_lo),
    .be_hi    (be_hi),
    .wdata_lo (wdata_lo),
    .wdata_hi (wdata_hi),
    .ld_data  (ld_data)
  );

  // Request capture and load-beat selection; *_d fields are the request in flight.
  always_comb begin
    accept = (state_q == S_IDLE) && req_valid;
    if (accept) begin
      write_d = req_write;
      ctrl_d  = req_addr_ctrl;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else begin
      write_d = write_q;
      ctrl_d  = ctrl_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end
    split     = is_split(ctrl_d, addr_d[1:0]);
    legal     = is_legal(write_d, ctrl_d);
    word_addr = {addr_d[ADDR_WIDTH-1:2], 2'b00};
    if ((state_q == S_WAIT0) && mem_rvalid) begin
      lo_d = mem_rdata;
    end else begin
      lo_d = lo_q;
    end
    // Second beat completes with the saved first word underneath it.
    if (state_q == S_WAIT1) begin
      ld_lo = lo_q;
      ld_hi = mem_rdata;
    end else begin
      ld_lo = mem_rdata;
      ld_hi = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = legal ? S_BEAT0 : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BEAT0: begin
        if (mem_gnt) begin
          if (write_q) begin
            state_d = split ? S_BEAT1 : S_RESP;
          end else begin
            state_d = S_WAIT0;
          end
        end else begin
          state_d = S_BEAT0;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          state_d = split ? S_BEAT1 : S_RESP;
        end else begin
          state_d = S_WAIT0;
        end
      end
      S_BEAT1: begin
        if (mem_gnt) begin
          state_d = write_q ? S_RESP : S_WAIT1;
        end else begin
          state_d = S_BEAT1;
        end
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = (state_d == S_RESP) && !legal;
    mem_req_d    = (state_d == S_BEAT0) || (state_d == S_BEAT1);
    mem_we_d     = mem_req_d && write_d;
    if ((state_d == S_RESP) && legal && !write_d) begin
      resp_rdata_d = ld_data;
    end else begin
      resp_rdata_d = {DATA_WIDTH{1'b0}};
    end
    case (state_d)
      S_BEAT0: begin
        mem_addr_d  = word_addr;
        mem_be_d    = be_lo;
        mem_wdata_d = write_d ? wdata_lo : {DATA_WIDTH{1'b0}};
      end
      S_BEAT1: begin
        mem_addr_d  = word_addr + WORD_STEP;
        mem_be_d    = be_hi;
        mem_wdata_d = write_d ? wdata_hi : {DATA_WIDTH{1'b0}};
      end
      default: begin
        mem_addr_d  = {ADDR_WIDTH{1'b0}};
        mem_be_d    = 4'b0000;
        mem_wdata_d = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request, beat-0 data and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      ctrl_q       <= 3'b000;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      lo_q         <= {DATA_WIDTH{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DATA_WIDTH{1'b0}};
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      write_q      <= write_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized bench for load_store_unit.
// A byte-addressed reference memory predicts every load result; a word-level
// bus memory answers the DUT's beats. The two are compared at the end.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_addr_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr_ctrl(req_addr_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- memories ----------------
  logic [31:0] bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E37_79B1;
    return t[31:24] ^ t[7:0];
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] wa);
    logic [31:0] w;
    if (bus_mem.exists(wa)) return bus_mem[wa];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(wa + 32'(i));
    return w;
  endfunction

  function automatic void bus_write(input logic [31:0] wa, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = bus_read(wa);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    bus_mem[wa] = w;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic void preload(input logic [31:0] wa, input logic [31:0] w);
    bus_mem[wa] = w;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = w[8*i +: 8];
  endfunction

  // ---------------- bus responder ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  beat_t       beat_log[$];
  beat_t       seen = '0;
  logic        fast = 1'b1;
  logic        gnt_hold = 1'b0;
  logic        stray = 1'b0;
  logic        noise = 1'b0;
  logic        rd_pending = 1'b0;
  logic        wait_prev = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  int          rd_wait = 0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (!rst_n) begin
      rd_pending = 1'b0;
      wait_prev  = 1'b0;
      mem_gnt    = 1'b0;
    end else begin
      if (wait_prev) begin
        check_val("bus_hold_req", 32'(mem_req), 32'd1);
        check_val("bus_hold_addr", mem_addr, seen.addr);
        check_val("bus_hold_be", 32'(mem_be), 32'(seen.be));
        check_val("bus_hold_wdata", mem_wdata, seen.wdata);
      end
      if (mem_gnt) begin
        beat_log.push_back(seen);
        if (seen.we) begin
          bus_write(seen.addr, seen.be, seen.wdata);
        end else begin
          rd_pending = 1'b1;
          rd_addr    = seen.addr;
          rd_wait    = fast ? 0 : int'($urandom_range(0, 2));
        end
      end
      if (rd_pending) begin
        if (rd_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = bus_read(rd_addr);
          rd_pending = 1'b0;
        end else begin
          rd_wait--;
        end
      end else if (stray || (noise && $urandom_range(0, 7) == 0)) begin
        mem_rvalid = 1'b1;  // nothing is outstanding, so the DUT must ignore this
      end
      if (mem_req) check_val("bus_word_aligned", 32'(mem_addr[1:0]), 32'd0);
      seen      = '{mem_we, mem_addr, mem_be, mem_wdata};
      mem_gnt   = mem_req && !gnt_hold && (fast || $urandom_range(0, 3) != 0);
      wait_prev = mem_req && !mem_gnt;
    end
  end

  // ---------------- request driver and reference ----------------
  task automatic do_req(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check_val("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr_ctrl = c; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
    check_val("busy_after_accept", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    check_val("resp_seen", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    check_val("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  task automatic run_one(input logic w, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got, output int lat);
    int          n;
    logic        exp_err, er;
    logic [31:0] exp, v;
    n = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    exp_err = !((c == 3'b000) || (c == 3'b001) || (c == 3'b010) ||
                (!w && ((c == 3'b100) || (c == 3'b101))));
    exp = 32'h0;
    if (!exp_err && !w) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
      if (!c[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      else if (!c[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      exp = v;
    end
    do_req(w, c, a, d, got, er, lat);
    check_val("rdata", got, exp);
    check_val("err", 32'(er), 32'(exp_err));
    if (!exp_err && w) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a, d, rw;
    logic [2:0]  c;
    logic        w;
    int          lat, k;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_resp_err", 32'(resp_err), 32'd0);
    check_val("rst_resp_rdata", resp_rdata, 32'd0);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_be", 32'(mem_be), 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Aligned load word
    preload(32'h100, 32'hDEAD_BEEF);
    run_one(1'b0, 3'b010, 32'h100, 32'h0, got, lat);
    check_val("lw_value", got, 32'hDEAD_BEEF);
    check_val("lw_latency", 32'(lat), 32'd3);

    // Signed / unsigned byte
    preload(32'h100, 32'h80FF_FF00);
    run_one(1'b0, 3'b000, 32'h103, 32'h0, got, lat);
    check_val("lb_value", got, 32'hFFFF_FF80);
    run_one(1'b0, 3'b100, 32'h103, 32'h0, got, lat);
    check_val("lbu_value", got, 32'h0000_0080);

    // Aligned store
    run_one(1'b1, 3'b010, 32'h120, 32'hCAFE_F00D, got, lat);
    check_val("sw_aligned_latency", 32'(lat), 32'd2);

    // Split store word
    beat_log.delete();
    run_one(1'b1, 3'b010, 32'h202, 32'h1122_3344, got, lat);
    check_val("sw_split_latency", 32'(lat), 32'd3);
    check_val("sw_split_beats", 32'(beat_log.size()), 32'd2);
    if (beat_log.size() == 2) begin
      check_val("sw_b0_addr", beat_log[0].addr, 32'h200);
      check_val("sw_b0_be", 32'(beat_log[0].be), 32'hC);
      check_val("sw_b0_wdata", beat_log[0].wdata, 32'h3344_0000);
      check_val("sw_b0_we", 32'(beat_log[0].we), 32'd1);
      check_val("sw_b1_addr", beat_log[1].addr, 32'h204);
      check_val("sw_b1_be", 32'(beat_log[1].be), 32'h3);
      check_val("sw_b1_wdata", beat_log[1].wdata, 32'h0000_1122);
    end

    // Split load half
    preload(32'h1FC, 32'hAB00_0000);
    preload(32'h200, 32'h0000_00CD);
    beat_log.delete();
    run_one(1'b0, 3'b001, 32'h1FF, 32'h0, got, lat);
    check_val("lh_split_value", got, 32'hFFFF_CDAB);
    check_val("lh_split_latency", 32'(lat), 32'd5);
    check_val("lh_split_beats", 32'(beat_log.size()), 32'd2);
    if (beat_log.size() == 2) begin
      check_val("lh_b0", {beat_log[0].addr[31:4], beat_log[0].be}, {28'h000_001F, 4'b1000});
      check_val("lh_b1", {beat_log[1].addr[31:4], beat_log[1].be}, {28'h000_0020, 4'b0001});
    end

    // Split load word wrapping the address space
    run_one(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, got, lat);

    // Illegal codes
    beat_log.delete();
    run_one(1'b0, 3'b011, 32'h100, 32'h0, got, lat);
    check_val("illegal_ld_latency", 32'(lat), 32'd1);
    run_one(1'b1, 3'b100, 32'h104, 32'h5555_AAAA, got, lat);
    check_val("illegal_st_latency", 32'(lat), 32'd1);
    check_val("illegal_no_bus", 32'(beat_log.size()), 32'd0);

    // Reset while a beat waits for grant
    gnt_hold = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr_ctrl = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) begin
      check_val("stall_mem_req", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_mem_req", 32'(mem_req), 32'd0);
    check_val("async_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1; gnt_hold = 1'b0; stray = 1'b1;
    @(negedge clk);
    #1 stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_val("stray_rvalid_no_resp", 32'(resp_valid), 32'd0);
    end

    // Randomized traffic with grant/rvalid delays and idle rvalid noise
    fast = 1'b0;
    noise = 1'b1;
    for (int t = 0; t < 300; t++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        c = 3'($urandom_range(0, 7));
      end else if (w) begin
        c = 3'($urandom_range(0, 2));
      end else begin
        k = int'($urandom_range(0, 4));
        c = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 63));
      d = $urandom();
      run_one(w, c, a, d, got, lat);
    end

    // Bus memory must hold exactly the bytes the reference says were stored
    for (int i = 0; i < 24; i++) begin
      if (i < 17) a = 32'h100 + 32'(4 * i);
      else if (i < 20) a = 32'h1FC + 32'(4 * (i - 17));
      else if (i < 22) a = 32'hFFFF_FFF8 + 32'(4 * (i - 20));
      else a = 32'(4 * (i - 22));
      for (int j = 0; j < 4; j++) rw[8*j +: 8] = ref_rd(a + 32'(j));
      check_val("mem_final", bus_read(a), rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
